// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg
// Shared definitions for the multicycle controller: the FSM state enum,
// the RV32I base opcodes it recognises, the datapath select encodings and
// two small decode helpers used by the controller.
// Build option: define ILLEGAL_TRAP_EN to add the TRAP state.
package multicycle_control_pkg;

  // FSM states; TRAP only exists when illegal-opcode trapping is built in
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEMRD  = 3'd3,
    MEMWR  = 3'd4,
    WB     = 3'd5,
    BRTGT  = 3'd6
`ifdef ILLEGAL_TRAP_EN
    ,
    TRAP   = 3'd7
`endif
  } state_t;

  typedef logic [1:0] sel2_t;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ALU operand A select
  localparam sel2_t ASRC_PC    = 2'b00;
  localparam sel2_t ASRC_RS1   = 2'b01;
  localparam sel2_t ASRC_OLDPC = 2'b10;
  localparam sel2_t ASRC_ZERO  = 2'b11;

  // ALU operand B select
  localparam sel2_t BSRC_RS2   = 2'b00;
  localparam sel2_t BSRC_IMM   = 2'b01;
  localparam sel2_t BSRC_FOUR  = 2'b10;

  // Request to the ALU control block
  localparam sel2_t ALUOP_ADD    = 2'b00;
  localparam sel2_t ALUOP_BRANCH = 2'b01;
  localparam sel2_t ALUOP_RTYPE  = 2'b10;
  localparam sel2_t ALUOP_ITYPE  = 2'b11;

  // Register-file writeback source
  localparam sel2_t WB_ALU = 2'b00;
  localparam sel2_t WB_MEM = 2'b01;
  localparam sel2_t WB_PC4 = 2'b10;

  // Instruction classes the controller distinguishes
  typedef enum logic [3:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_OP,
    CLS_OPIMM,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_BRANCH,
    CLS_ILLEGAL
  } opclass_t;

  // The three ALU-side selects travel together
  typedef struct packed {
    sel2_t src_a;
    sel2_t src_b;
    sel2_t aluop;
  } alu_sel_t;

  function automatic opclass_t classify(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_OP:     return CLS_OP;
      OPC_OPIMM:  return CLS_OPIMM;
      OPC_LUI:    return CLS_LUI;
      OPC_AUIPC:  return CLS_AUIPC;
      OPC_JAL:    return CLS_JAL;
      OPC_JALR:   return CLS_JALR;
      OPC_BRANCH: return CLS_BRANCH;
      default:    return CLS_ILLEGAL;
    endcase
  endfunction

  // ALU selects used in EXEC; memory and writeback states keep these so the
  // address / result stays valid. Jumps compute their target here already.
  // Unrecognised opcodes get all-zero selects.
  function automatic alu_sel_t exec_sel(input opclass_t cls);
    alu_sel_t s;
    s = '0;
    case (cls)
      CLS_LOAD, CLS_STORE: s = '{ASRC_RS1,   BSRC_IMM, ALUOP_ADD};
      CLS_OP:              s = '{ASRC_RS1,   BSRC_RS2, ALUOP_RTYPE};
      CLS_OPIMM:           s = '{ASRC_RS1,   BSRC_IMM, ALUOP_ITYPE};
      CLS_LUI:             s = '{ASRC_ZERO,  BSRC_IMM, ALUOP_ADD};
      CLS_AUIPC:           s = '{ASRC_OLDPC, BSRC_IMM, ALUOP_ADD};
      CLS_JAL:             s = '{ASRC_OLDPC, BSRC_IMM, ALUOP_ADD};
      CLS_JALR:            s = '{ASRC_RS1,   BSRC_IMM, ALUOP_ADD};
      CLS_BRANCH:          s = '{ASRC_RS1,   BSRC_RS2, ALUOP_BRANCH};
      default:             s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if
// Control bundle between the multicycle controller and its datapath/memory:
// IR contents and status come in, strobes and mux selects go out.
// The controller uses the master modport, the datapath side the slave one.
interface multicycle_control_if;
  import multicycle_control_pkg::*;

  logic [31:0] instr;
  logic        mem_ready;
  logic        alu_zero;

  logic        mem_req;
  logic        mem_we;
  logic        mem_iord;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  sel2_t       alusrc_a;
  sel2_t       alusrc_b;
  sel2_t       aluop;
  sel2_t       wb_sel;
  logic        mem_timeout;

  modport master (
    input  instr, mem_ready, alu_zero,
    output mem_req, mem_we, mem_iord, ir_write, pc_write, reg_write,
           alusrc_a, alusrc_b, aluop, wb_sel, mem_timeout
  );

  modport slave (
    output instr, mem_ready, alu_zero,
    input  mem_req, mem_we, mem_iord, ir_write, pc_write, reg_write,
           alusrc_a, alusrc_b, aluop, wb_sel, mem_timeout
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
// Main control FSM of a multicycle RV32I core. Outputs are decoded from the
// state register; only the FETCH load strobes and the timeout pulse also
// look at mem_ready. An 8-bit wait counter aborts memory accesses that stall
// for WAIT_MAX cycles (legal range 1..255) and restarts at FETCH.
// Build option: ILLEGAL_TRAP_EN makes unrecognised opcodes lock in TRAP;
// without it they behave as a NOP.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input logic clk,
  input logic reset,
  multicycle_control_if.master bus
);

  localparam logic [7:0] WAIT_CNT_MAX = WAIT_MAX[7:0];

  state_t     state;
  logic [7:0] wait_cnt;

  opclass_t   cls;
  alu_sel_t   esel;
  logic       taken;

  logic       req_c;
  logic       we_c;
  logic       iord_c;
  logic       irw_c;
  logic       pcw_c;
  logic       rw_c;
  alu_sel_t   sel_c;
  sel2_t      wb_c;
  logic       timeout_c;

  logic       unused_instr_bits;

  assign cls   = classify(bus.instr[6:0]);
  assign esel  = exec_sel(cls);
  // funct3[0] flips the sense of the zero flag (BEQ/BNE, BLT/BGE, ...)
  assign taken = bus.alu_zero ^ bus.instr[12];

  assign unused_instr_bits = ^{bus.instr[31:13], bus.instr[11:7]};

  // A stalled request expires when the counter has reached the limit and the
  // memory still is not ready; a ready in that same cycle wins.
  assign timeout_c = req_c && !bus.mem_ready && (wait_cnt == WAIT_CNT_MAX);

  // Per-state decode of strobes and datapath selects
  always_comb begin
    req_c  = 1'b0;
    we_c   = 1'b0;
    iord_c = 1'b0;
    irw_c  = 1'b0;
    pcw_c  = 1'b0;
    rw_c   = 1'b0;
    sel_c  = '0;
    wb_c   = WB_ALU;
    unique case (state)
      FETCH: begin
        req_c = 1'b1;
        sel_c = '{ASRC_PC, BSRC_FOUR, ALUOP_ADD};
        irw_c = bus.mem_ready;
        pcw_c = bus.mem_ready;
      end
      DECODE: begin
        sel_c = '0;
      end
      EXEC: begin
        sel_c = esel;
      end
      MEMRD: begin
        req_c  = 1'b1;
        iord_c = 1'b1;
        sel_c  = esel;
      end
      MEMWR: begin
        req_c  = 1'b1;
        we_c   = 1'b1;
        iord_c = 1'b1;
        sel_c  = esel;
      end
      WB: begin
        rw_c  = 1'b1;
        sel_c = esel;
        if (cls == CLS_JAL || cls == CLS_JALR) begin
          pcw_c = 1'b1;
          wb_c  = WB_PC4;
        end else if (cls == CLS_LOAD) begin
          wb_c  = WB_MEM;
        end
      end
      BRTGT: begin
        pcw_c = 1'b1;
        sel_c = '{ASRC_OLDPC, BSRC_IMM, ALUOP_ADD};
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: begin
        sel_c = '0;
      end
`endif
      default: begin
        sel_c = '0;
      end
    endcase
  end

  // Reset forces every output low immediately, aborting any access in flight
  always_comb begin
    if (reset) begin
      bus.mem_req     = 1'b0;
      bus.mem_we      = 1'b0;
      bus.mem_iord    = 1'b0;
      bus.ir_write    = 1'b0;
      bus.pc_write    = 1'b0;
      bus.reg_write   = 1'b0;
      bus.alusrc_a    = '0;
      bus.alusrc_b    = '0;
      bus.aluop       = '0;
      bus.wb_sel      = '0;
      bus.mem_timeout = 1'b0;
    end else begin
      bus.mem_req     = req_c;
      bus.mem_we      = we_c;
      bus.mem_iord    = iord_c;
      bus.ir_write    = irw_c;
      bus.pc_write    = pcw_c;
      bus.reg_write   = rw_c;
      bus.alusrc_a    = sel_c.src_a;
      bus.alusrc_b    = sel_c.src_b;
      bus.aluop       = sel_c.aluop;
      bus.wb_sel      = wb_c;
      bus.mem_timeout = timeout_c;
    end
  end

  // State register and wait counter; the counter only survives cycles in
  // which a request is stalled, so any state change clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      if (req_c && !bus.mem_ready && !timeout_c) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end

      unique case (state)
        FETCH: begin
          if (bus.mem_ready) begin
            state <= DECODE;
          end
        end
        DECODE: begin
          state <= EXEC;
        end
        EXEC: begin
          unique case (cls)
            CLS_LOAD:   state <= MEMRD;
            CLS_STORE:  state <= MEMWR;
            CLS_BRANCH: state <= taken ? BRTGT : FETCH;
`ifdef ILLEGAL_TRAP_EN
            CLS_ILLEGAL: state <= TRAP;
`else
            CLS_ILLEGAL: state <= FETCH;
`endif
            default:    state <= WB;
          endcase
        end
        MEMRD: begin
          if (bus.mem_ready) begin
            state <= WB;
          end else if (timeout_c) begin
            state <= FETCH;
          end
        end
        MEMWR: begin
          if (bus.mem_ready || timeout_c) begin
            state <= FETCH;
          end
        end
        WB: begin
          state <= FETCH;
        end
        BRTGT: begin
          state <= FETCH;
        end
`ifdef ILLEGAL_TRAP_EN
        TRAP: begin
          state <= TRAP;
        end
`endif
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
